// File: rtl/regbank_wr_arbiter.sv
// Round-robin arbiter sharing the register-bank write port between ALU (A) and load unit (B), plus RAW scoreboard.
// Grants are combinational; the winning write reaches We/Addr_Rd/W_Data one cycle later. Never stalls a lone requester.
module regbank_wr_arbiter #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Req_A,
    input  logic [AW-1:0]     Addr_A,
    input  logic [DW-1:0]     Data_A,
    output logic              Gnt_A,
    input  logic              Req_B,
    input  logic [AW-1:0]     Addr_B,
    input  logic [DW-1:0]     Data_B,
    output logic              Gnt_B,
    input  logic              Rsv_Valid,
    input  logic [AW-1:0]     Rsv_Addr,
    output logic              We,
    output logic [AW-1:0]     Addr_Rd,
    output logic [DW-1:0]     W_Data,
    output logic [2**AW-1:0]  Busy
);

    localparam int NREG = 2**AW;

    logic            r_last_b;
    logic            r_we;
    logic [AW-1:0]   r_addr_rd;
    logic [DW-1:0]   r_w_data;
    logic [NREG-1:0] r_busy;

    logic            w_gnt_a;
    logic            w_gnt_b;
    logic            w_xfer;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_data;
    logic [NREG-1:0] w_busy_nxt;

    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (!Rst) begin
            // On a tie, the source that did not win last time goes first.
            if (Req_A && (!Req_B || r_last_b)) begin
                w_gnt_a = 1'b1;
            end else if (Req_B) begin
                w_gnt_b = 1'b1;
            end
        end
    end

    assign w_xfer = w_gnt_a | w_gnt_b;
    assign w_addr = w_gnt_a ? Addr_A : Addr_B;
    assign w_data = w_gnt_a ? Data_A : Data_B;

    // Clear first, then set, so a same-edge reservation of the retiring register wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we) begin
            w_busy_nxt[r_addr_rd] = 1'b0;
        end
        if (Rsv_Valid && (Rsv_Addr != '0)) begin
            w_busy_nxt[Rsv_Addr] = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_last_b  <= 1'b1;
            r_we      <= 1'b0;
            r_addr_rd <= '0;
            r_w_data  <= '0;
            r_busy    <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            // R0 is hardwired: the source is released but nothing is written.
            r_we   <= w_xfer && (w_addr != '0);
            if (w_xfer) begin
                r_addr_rd <= w_addr;
                r_w_data  <= w_data;
                r_last_b  <= w_gnt_b;
            end
        end
    end

    assign Gnt_A   = w_gnt_a;
    assign Gnt_B   = w_gnt_b;
    assign We      = r_we;
    assign Addr_Rd = r_addr_rd;
    assign W_Data  = r_w_data;
    assign Busy    = r_busy;

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Bench for regbank_wr_arbiter: directed scenarios with literal expectations, then randomized traffic vs. a rule model.
module tb_regbank_wr_arbiter;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          Req_A, Req_B, Rsv_Valid;
    logic [AW-1:0] Addr_A, Addr_B, Rsv_Addr;
    logic [DW-1:0] Data_A, Data_B;
    logic          Gnt_A, Gnt_B, We;
    logic [AW-1:0] Addr_Rd;
    logic [DW-1:0] W_Data;
    logic [15:0]   Busy;

    int n_checks = 0;
    int n_fail   = 0;

    regbank_wr_arbiter #(.DW(DW), .AW(AW)) dut (
        .Clk(Clk), .Rst(Rst),
        .Req_A(Req_A), .Addr_A(Addr_A), .Data_A(Data_A), .Gnt_A(Gnt_A),
        .Req_B(Req_B), .Addr_B(Addr_B), .Data_B(Data_B), .Gnt_B(Gnt_B),
        .Rsv_Valid(Rsv_Valid), .Rsv_Addr(Rsv_Addr),
        .We(We), .Addr_Rd(Addr_Rd), .W_Data(W_Data), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who won last, the write the bank sees next, and which registers are reserved.
    logic          m_last_a;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    bit   [15:0]   m_busy;
    logic          m_ga, m_gb;
    logic          ga, gb;

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            m_last_a = 1'b0;
            m_we     = 1'b0;
            m_addr   = '0;
            m_data   = '0;
            m_busy   = '0;
            m_ga     = 1'b0;
            m_gb     = 1'b0;
        end else begin
            ga = Req_A && (!Req_B || !m_last_a);
            gb = Req_B && !ga;
            if (m_we) m_busy[m_addr] = 1'b0;
            if (Rsv_Valid && Rsv_Addr != 0) m_busy[Rsv_Addr] = 1'b1;
            if (ga || gb) begin
                m_last_a = ga;
                m_addr   = ga ? Addr_A : Addr_B;
                m_data   = ga ? Data_A : Data_B;
                m_we     = (m_addr != 0);
            end else begin
                m_we = 1'b0;
            end
            m_ga = ga;
            m_gb = gb;
        end
    end

    logic eg_a, eg_b;
    always @(negedge Clk) begin
        eg_a = !Rst && Req_A && (!Req_B || !m_last_a);
        eg_b = !Rst && Req_B && !(Req_A && (!Req_B || !m_last_a));
        chk("model_gnt_a", Gnt_A, eg_a);
        chk("model_gnt_b", Gnt_B, eg_b);
        chk("model_we", We, m_we);
        if (m_we) begin
            chk("model_addr_rd", Addr_Rd, m_addr);
            chk("model_w_data", W_Data, m_data);
        end
        chk("model_busy", Busy, m_busy);
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic ra, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                         input logic rb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                         input logic rv, input logic [AW-1:0] radr);
        Req_A = ra; Addr_A = aa; Data_A = da;
        Req_B = rb; Addr_B = ab; Data_B = db;
        Rsv_Valid = rv; Rsv_Addr = radr;
    endtask

    initial begin
        Rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1 Rst = 1'b1;

        // Reset and idle
        repeat (2) @(posedge Clk);
        #2 Rst = 1'b0;
        repeat (2) tick;
        #2 Rst = 1'b1;
        #1;
        chk("rst_we", We, 0);
        chk("rst_busy", Busy, 16'h0000);
        #3 Rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            @(negedge Clk);
            chk("idle_we", We, 0);
        end

        // Contention: A first after reset, then alternate
        tick;
        drive(1, 1, 16'h0001, 1, 2, 16'h0002, 0, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            if (c < 4) begin
                chk("rr_gnt_a", Gnt_A, (c % 2 == 0));
                chk("rr_gnt_b", Gnt_B, (c % 2 == 1));
            end
            if (c >= 1) begin
                chk("rr_we", We, 1);
                chk("rr_addr", Addr_Rd, (c % 2 == 1) ? 1 : 2);
                chk("rr_data", W_Data, (c % 2 == 1) ? 16'h0001 : 16'h0002);
            end
            tick;
            if (c == 3) drive(0, 0, 0, 0, 0, 0, 0, 0);
        end

        // Single source A
        drive(1, 3, 16'hBEEF, 0, 0, 0, 0, 0);
        @(negedge Clk);
        chk("single_gnt_a", Gnt_A, 1);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge Clk);
        chk("single_we", We, 1);
        chk("single_addr", Addr_Rd, 3);
        chk("single_data", W_Data, 16'hBEEF);
        tick;
        @(negedge Clk);
        chk("single_we_drop", We, 0);

        // Scoreboard set / clear / set-wins
        tick;
        drive(0, 0, 0, 0, 0, 0, 1, 5);
        tick;
        drive(0, 0, 0, 1, 5, 16'h1234, 0, 0);
        @(negedge Clk);
        chk("sb_set", Busy, 16'h0020);
        chk("sb_gnt_b", Gnt_B, 1);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge Clk);
        chk("sb_we", We, 1);
        chk("sb_addr", Addr_Rd, 5);
        chk("sb_busy_before_clear", Busy, 16'h0020);
        tick;
        @(negedge Clk);
        chk("sb_clear", Busy, 16'h0000);
        tick;
        drive(0, 0, 0, 0, 0, 0, 1, 5);
        tick;
        drive(0, 0, 0, 1, 5, 16'h5555, 0, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 1, 5);
        @(negedge Clk);
        chk("sb_same_edge_we", We, 1);
        chk("sb_same_edge_addr", Addr_Rd, 5);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge Clk);
        chk("sb_set_wins", Busy, 16'h0020);

        // R0 writes and R0 reservations
        tick;
        drive(1, 0, 16'hFFFF, 0, 0, 0, 0, 0);
        @(negedge Clk);
        chk("r0_gnt_a", Gnt_A, 1);
        tick;
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge Clk);
        chk("r0_we", We, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge Clk);
        chk("r0_busy", Busy, 16'h0020);

        // Reset in the middle of a write stream
        tick;
        drive(1, 9, 16'h0909, 1, 10, 16'h0A0A, 0, 0);
        tick;
        #2 Rst = 1'b1;
        #1;
        chk("mid_rst_we", We, 0);
        chk("mid_rst_busy", Busy, 16'h0000);
        chk("mid_rst_gnt_a", Gnt_A, 0);
        chk("mid_rst_gnt_b", Gnt_B, 0);
        @(posedge Clk);
        #3 Rst = 1'b0;
        #1;
        chk("post_rst_gnt_a", Gnt_A, 1);
        chk("post_rst_gnt_b", Gnt_B, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic; sources hold their request until granted
        for (int i = 0; i < 3000; i++) begin
            tick;
            if (!Req_A || m_ga) begin
                Req_A  = ($urandom_range(0, 99) < 60);
                Addr_A = AW'($urandom);
                Data_A = DW'($urandom);
            end
            if (!Req_B || m_gb) begin
                Req_B  = ($urandom_range(0, 99) < 60);
                Addr_B = AW'($urandom);
                Data_B = DW'($urandom);
            end
            Rsv_Valid = ($urandom_range(0, 99) < 30);
            Rsv_Addr  = AW'($urandom);
            if (i % 1000 == 500) begin
                #2 Rst = 1'b1;
                #4 Rst = 1'b0;
            end
        end

        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
